// File: rtl/boreal_rpeak_detect.sv
// R-peak detector: first-difference magnitude, adaptive threshold, refractory window, beat pulse with RR/amp.
// Optional idle threshold decay is built when BOREAL_RPEAK_DECAY_EN is defined.
module boreal_rpeak_detect #(
   parameter int unsigned SAMPLE_W    = 24,
   parameter int unsigned RR_W        = 16,
   parameter int unsigned THRESH_INIT = 1000,
   parameter int unsigned THRESH_MIN  = 64,
   parameter int unsigned DECAY_SHIFT = 3,
   parameter int unsigned REFRACT     = 50,
   parameter int unsigned MAX_WIDTH   = 40
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] x,
   output logic                peak,
   output logic [RR_W-1:0]     rr,
   output logic                rr_valid,
   output logic [SAMPLE_W:0]   amp,
   output logic [SAMPLE_W:0]   thr
);

   localparam int unsigned MW   = SAMPLE_W + 1;
   localparam int unsigned TW   = SAMPLE_W + 3;
   localparam int unsigned WC_W = $clog2(MAX_WIDTH + 1);
   localparam int unsigned RC_W = $clog2(REFRACT + 1);
   localparam logic [RR_W-1:0] RR_MAX    = '1;
   localparam logic [TW-1:0]   THR_MAX   = TW'({MW{1'b1}});
   localparam logic [TW-1:0]   THR_FLOOR = TW'(THRESH_MIN);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_RISE    = 2'd1,
      S_REFRACT = 2'd2
   } state_e;

   // Clamp a widened threshold back into [THRESH_MIN, 2^MW-1].
   function automatic logic [MW-1:0] clamp_thr(input logic [TW-1:0] v);
      logic [TW-1:0] r;
      r = v;
      if (v < THR_FLOOR) begin
         r = THR_FLOOR;
      end else if (v > THR_MAX) begin
         r = THR_MAX;
      end
      return MW'(r);
   endfunction

   // Stage 1: |x - x_prev|, forced to zero on the first sample after reset.
   logic [SAMPLE_W-1:0]  x_prev_q;
   logic                 prime_q;
   logic                 m_valid_q;
   logic [MW-1:0]        m_q;
   logic signed [MW-1:0] diff_c;
   logic [MW-1:0]        mag_c;

   always_comb begin
      diff_c = MW'($signed(x)) - MW'($signed(x_prev_q));
      mag_c  = diff_c[MW-1] ? $unsigned(-diff_c) : $unsigned(diff_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_prev_q  <= '0;
         prime_q   <= 1'b0;
         m_valid_q <= 1'b0;
         m_q       <= '0;
      end else begin
         m_valid_q <= in_valid;
         if (in_valid) begin
            x_prev_q <= x;
            prime_q  <= 1'b1;
            m_q      <= prime_q ? mag_c : '0;
         end
      end
   end

   // Stage 2 state
   state_e          state_q, state_d;
   logic [MW-1:0]   pk_q, pk_d;
   logic [WC_W-1:0] wcnt_q, wcnt_d;
   logic [RC_W-1:0] rcnt_q, rcnt_d;
   logic [RR_W-1:0] rr_cnt_q, rr_cnt_d;
   logic            seen_q, seen_d;
   logic            peak_q, peak_d;
   logic [RR_W-1:0] rr_q, rr_d;
   logic            rr_valid_q, rr_valid_d;
   logic [MW-1:0]   amp_q, amp_d;
   logic [MW-1:0]   thr_q, thr_d;

   logic            emit_c;
   logic [MW-1:0]   pk_sel_c;
   logic [TW-1:0]   thr_ext_c;
   logic [TW-1:0]   thr_raw_c;
   logic [RR_W-1:0] rr_sat_c;
   logic            decay_fire_c;
   logic [MW-1:0]   thr_decay_c;

   always_comb begin
      pk_sel_c  = (m_q >= pk_q) ? m_q : pk_q;
      thr_ext_c = TW'(thr_q);
      thr_raw_c = thr_ext_c - (thr_ext_c >> DECAY_SHIFT) + (TW'(pk_sel_c >> 1) >> DECAY_SHIFT);
      rr_sat_c  = (rr_cnt_q == RR_MAX) ? RR_MAX : rr_cnt_q + RR_W'(1);
   end

`ifdef BOREAL_RPEAK_DECAY_EN
   // Idle decay: every 256 quiet SEARCH samples shave thr by 1/16.
   logic [7:0] dcnt_q, dcnt_d;

   always_comb begin
      dcnt_d       = dcnt_q;
      decay_fire_c = 1'b0;
      thr_decay_c  = clamp_thr(TW'(thr_q) - (TW'(thr_q) >> 4));
      if (m_valid_q) begin
         if ((state_q == S_SEARCH) && !(m_q > thr_q)) begin
            if (dcnt_q == 8'd255) begin
               decay_fire_c = 1'b1;
               dcnt_d       = '0;
            end else begin
               dcnt_d = dcnt_q + 8'd1;
            end
         end else begin
            dcnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_q <= '0;
      end else begin
         dcnt_q <= dcnt_d;
      end
   end
`else
   assign decay_fire_c = 1'b0;
   assign thr_decay_c  = thr_q;
`endif

   // Beat FSM next-state and output logic; EMIT is folded into the RISE sample.
   always_comb begin
      state_d    = state_q;
      pk_d       = pk_q;
      wcnt_d     = wcnt_q;
      rcnt_d     = rcnt_q;
      rr_cnt_d   = rr_cnt_q;
      seen_d     = seen_q;
      peak_d     = 1'b0;
      rr_d       = rr_q;
      rr_valid_d = rr_valid_q;
      amp_d      = amp_q;
      thr_d      = thr_q;
      emit_c     = 1'b0;
      if (m_valid_q) begin
         case (state_q)
            S_SEARCH: begin
               if (m_q > thr_q) begin
                  state_d = S_RISE;
                  pk_d    = m_q;
                  wcnt_d  = WC_W'(1);
               end
            end
            S_RISE: begin
               pk_d = pk_sel_c;
               if ((m_q < thr_q) || (wcnt_q == WC_W'(MAX_WIDTH))) begin
                  emit_c = 1'b1;
               end else begin
                  wcnt_d = wcnt_q + WC_W'(1);
               end
            end
            S_REFRACT: begin
               if (rcnt_q <= RC_W'(1)) begin
                  state_d = S_SEARCH;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q - RC_W'(1);
               end
            end
            default: state_d = S_SEARCH;
         endcase

         if (emit_c) begin
            peak_d     = 1'b1;
            amp_d      = pk_sel_c;
            rr_d       = rr_sat_c;
            rr_valid_d = seen_q;
            seen_d     = 1'b1;
            rr_cnt_d   = '0;
            thr_d      = clamp_thr(thr_raw_c);
            rcnt_d     = RC_W'(REFRACT);
            state_d    = S_REFRACT;
         end else if (seen_q && (rr_cnt_q != RR_MAX)) begin
            rr_cnt_d = rr_cnt_q + RR_W'(1);
         end

         if (decay_fire_c) begin
            thr_d = thr_decay_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_SEARCH;
         pk_q       <= '0;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         rr_cnt_q   <= '0;
         seen_q     <= 1'b0;
         peak_q     <= 1'b0;
         rr_q       <= '0;
         rr_valid_q <= 1'b0;
         amp_q      <= '0;
         thr_q      <= MW'(THRESH_INIT);
      end else begin
         state_q    <= state_d;
         pk_q       <= pk_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         rr_cnt_q   <= rr_cnt_d;
         seen_q     <= seen_d;
         peak_q     <= peak_d;
         rr_q       <= rr_d;
         rr_valid_q <= rr_valid_d;
         amp_q      <= amp_d;
         thr_q      <= thr_d;
      end
   end

   assign peak     = peak_q;
   assign rr       = rr_q;
   assign rr_valid = rr_valid_q;
   assign amp      = amp_q;
   assign thr      = thr_q;

endmodule

// File: tb/tb_boreal_rpeak_detect.sv
// Self-checking bench for boreal_rpeak_detect: directed test-plan cases plus randomized traffic
// compared cycle by cycle against a sample-level behavioural model.
module tb_boreal_rpeak_detect;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [23:0] x;
   logic        peak;
   logic [15:0] rr;
   logic        rr_valid;
   logic [24:0] amp;
   logic [24:0] thr;

   boreal_rpeak_detect dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .x        (x),
      .peak     (peak),
      .rr       (rr),
      .rr_valid (rr_valid),
      .amp      (amp),
      .thr      (thr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state (plain integers, one step per valid sample)
   bit     md_primed;
   longint md_xprev;
   bit     md_s1_v;
   longint md_s1_m;
   int     md_mode;      // 0 searching, 1 inside a beat, 2 refractory
   longint md_pk;
   longint md_width;
   longint md_refr_left;
   longint md_since;
   bit     md_seen;
   longint md_win;
   longint md_thr;
   bit     e_peak;
   longint e_rr;
   bit     e_rrv;
   longint e_amp;

   // Observation log
   int     cyc_n;
   int     npk;
   longint l_amp;
   longint l_rr;
   bit     l_rrv;
   longint l_thr;
   int     l_cyc;

   task automatic chk(input string tag, input logic [67:0] o, input logic [67:0] e);
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, o, e);
   endtask

   task automatic model_reset();
      md_primed = 0; md_xprev = 0; md_s1_v = 0; md_s1_m = 0;
      md_mode = 0; md_pk = 0; md_width = 0; md_refr_left = 0;
      md_since = 0; md_seen = 0; md_win = 0; md_thr = 1000;
      e_peak = 0; e_rr = 0; e_rrv = 0; e_amp = 0;
   endtask

   // Advance the model by one clock with the given input.
   task automatic model_edge(input bit v, input longint xv);
      int     prev_mode;
      bit     emit;
      longint dd;
      prev_mode = md_mode;
      emit      = 0;
      e_peak    = 0;
      if (md_s1_v) begin
         if (md_mode == 0) begin
            if (md_s1_m > md_thr) begin
               md_mode = 1; md_pk = md_s1_m; md_width = 1;
            end
         end else if (md_mode == 1) begin
            if (md_s1_m >= md_pk) md_pk = md_s1_m;
            if (md_s1_m < md_thr || md_width == 40) emit = 1;
            else md_width++;
         end else begin
            md_refr_left--;
            if (md_refr_left == 0) md_mode = 0;
         end
         if (emit) begin
            e_peak = 1;
            e_amp  = md_pk;
            e_rr   = (md_since + 1 > 65535) ? 65535 : md_since + 1;
            e_rrv  = md_seen;
            md_seen  = 1;
            md_since = 0;
            md_thr   = md_thr - md_thr / 8 + (md_pk / 2) / 8;
            if (md_thr < 64) md_thr = 64;
            if (md_thr > 33554431) md_thr = 33554431;
            md_mode = 2;
            md_refr_left = 50;
         end else if (md_seen && md_since < 65535) begin
            md_since++;
         end
         if (prev_mode == 0 && md_mode == 0) begin
            md_win++;
            if (md_win == 256) begin
`ifdef BOREAL_RPEAK_DECAY_EN
               md_thr = md_thr - md_thr / 16;
               if (md_thr < 64) md_thr = 64;
`endif
               md_win = 0;
            end
         end else begin
            md_win = 0;
         end
      end
      md_s1_v = v;
      if (v) begin
         dd = xv - md_xprev;
         md_s1_m   = md_primed ? ((dd < 0) ? -dd : dd) : 0;
         md_primed = 1;
         md_xprev  = xv;
      end
   endtask

   // One clock: drive, step the model, compare every output.
   task automatic cyc(input bit v, input longint xv);
      in_valid = v;
      x        = 24'(xv);
      @(posedge clk);
      #1;
      cyc_n++;
      model_edge(v, xv);
      chk("cycle", 68'({peak, rr, rr_valid, amp, thr}),
          68'({e_peak, 16'(e_rr), e_rrv, 25'(e_amp), 25'(md_thr)}));
      if (peak) begin
         npk++; l_amp = amp; l_rr = rr; l_rrv = rr_valid; l_thr = thr; l_cyc = cyc_n;
      end
   endtask

   task automatic feed(input int n, input longint xv);
      for (int i = 0; i < n; i++) cyc(1'b1, xv);
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      model_reset();
      chk("reset", 68'({peak, rr, rr_valid, amp, thr}), 68'({1'b0, 16'd0, 1'b0, 25'd0, 25'd1000}));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      npk   = 0;
   endtask

   initial begin
      longint xc;
      int     follow;
      int     r;
      rst_n = 1'b1; in_valid = 1'b0; x = '0;
      cyc_n = 0; npk = 0; l_amp = 0; l_rr = 0; l_rrv = 0; l_thr = 0; l_cyc = 0;
      model_reset();
      #1;

      // Single step
      do_reset();
      feed(10, 0);
      cyc(1'b1, 5000);
      cyc(1'b1, 5000);
      follow = cyc_n;
      feed(10, 5000);
      chk("step_npk", 68'(npk), 68'(1));
      chk("step_lat", 68'(l_cyc), 68'(follow + 1));
      chk("step_amp", 68'(l_amp), 68'(5000));
      chk("step_thr", 68'(l_thr), 68'(1187));
      chk("step_rrv", 68'(l_rrv), 68'(0));

      // RR measurement: second step 200 samples after the first
      do_reset();
      feed(10, 0);
      feed(200, 5000);
      feed(60, 10000);
      chk("rr_npk", 68'(npk), 68'(2));
      chk("rr_val", 68'(l_rr), 68'(200));
      chk("rr_rrv", 68'(l_rrv), 68'(1));
      chk("rr_amp", 68'(l_amp), 68'(5000));

      // Refractory: step at 30 ignored, step at 120 detected
      do_reset();
      feed(10, 0);
      feed(30, 5000);
      feed(90, 10000);
      feed(60, 15000);
      chk("refr_npk", 68'(npk), 68'(2));
      chk("refr_rr", 68'(l_rr), 68'(120));
      chk("refr_amp", 68'(l_amp), 68'(5000));

      // Forced emit on a long ramp
      do_reset();
      feed(5, 0);
      for (int k = 1; k <= 60; k++) cyc(1'b1, 2000 * k);
      feed(50, 120000);
      chk("ramp_npk", 68'(npk), 68'(1));
      chk("ramp_amp", 68'(l_amp), 68'(2000));

      // First sample after reset carries no difference
      do_reset();
      feed(4, 5000);
      chk("prime_npk", 68'(npk), 68'(0));

      // Idle decay window
      do_reset();
      feed(256, 77);
      cyc(1'b0, 77);
`ifdef BOREAL_RPEAK_DECAY_EN
      chk("decay_thr", 68'(thr), 68'(938));
`else
      chk("decay_thr", 68'(thr), 68'(1000));
`endif

      // Reset in the middle of a beat discards it
      do_reset();
      feed(10, 0);
      feed(200, 5000);
      cyc(1'b1, 10000);
      cyc(1'b0, 10000);
      do_reset();
      feed(10, 0);
      feed(4, 5000);
      chk("midrst_npk", 68'(npk), 68'(1));
      chk("midrst_rrv", 68'(l_rrv), 68'(0));

      // Randomized traffic with gaps, steps, extremes and occasional resets
      do_reset();
      xc = 0;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(99));
         if (r < 55) begin
            xc = xc;
         end else if (r < 85) begin
            xc = xc + longint'($urandom_range(600)) - 300;
         end else if (r < 97) begin
            if ($urandom_range(1) == 1) xc = xc + longint'($urandom_range(8000, 1500));
            else xc = xc - longint'($urandom_range(8000, 1500));
         end else begin
            xc = ($urandom_range(1) == 1) ? 64'sd8388607 : -64'sd8388608;
         end
         if (xc > 8388607) xc = 8388607;
         if (xc < -8388608) xc = -8388608;
         if ($urandom_range(499) == 0) do_reset();
         cyc($urandom_range(99) < 75, xc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
